// File: rtl/dac_pkg.sv
// Shared types, default constants and sample-format helper for the DAC sample engine.
package dac_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    // 76.8 MHz / 1600 = 48 kHz sample rate
    localparam int unsigned DIV_48K       = 1600;
    localparam int unsigned LOCK_WAIT_DEF = 1024;
    localparam int unsigned BITS_MAX      = 32;

    // Two's complement to offset binary: flip the sign bit of a bits-wide sample
    function automatic logic [BITS_MAX-1:0] to_offset_binary(
        input logic [BITS_MAX-1:0] s,
        input int unsigned         bits
    );
        return s ^ (BITS_MAX'(1) << (bits - 1));
    endfunction

endpackage

// File: rtl/dac_dsm1.sv
// First-order 1-bit delta-sigma modulator: the carry out of a wrapping accumulator is the bitstream.
module dac_dsm1 #(
    parameter int unsigned BITS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [BITS-1:0] u,
    output logic            bit_out
);

    logic [BITS-1:0] acc;
    logic [BITS:0]   sum_c;

    // One extra bit captures the overflow that becomes the output bit
    assign sum_c = {1'b0, acc} + {1'b0, u};

    // Accumulator wraps by design; ones density equals u / 2^BITS
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc     <= '0;
            bit_out <= 1'b0;
        end else if (en) begin
            acc     <= sum_c[BITS-1:0];
            bit_out <= sum_c[BITS];
        end
    end

endmodule

// File: rtl/dac_sample_engine.sv
// Lock-gated 48 kHz sample engine: PLL lock qualification, sample strobe, one-deep input buffer, delta-sigma output.
module dac_sample_engine
    import dac_pkg::*;
#(
    parameter int unsigned BITS      = 16,
    parameter int unsigned DIV       = DIV_48K,
    parameter int unsigned LOCK_WAIT = LOCK_WAIT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            locked,
    input  logic [BITS-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            sample_tick,
    output logic            underrun,
    output logic            active,
    output logic            dac_out
);

    localparam int unsigned DW = $clog2(DIV);
    localparam int unsigned SW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [DW-1:0] DIV_LAST    = DW'(DIV - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_WAIT - 1);

    state_t          state, state_n;
    logic [SW-1:0]   settle_cnt, settle_n;
    logic [DW-1:0]   div_cnt, div_n;
    logic            pend_full, pend_full_n;
    logic [BITS-1:0] pend_data, pend_data_n;
    logic [BITS-1:0] cur, cur_n;
    logic            tick_n, underrun_n, in_ready_n, active_n;
    logic            xfer_c, clr_c;
    logic [BITS-1:0] u_c;

    // State and datapath registers; every output is a flop
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_LOCK;
            settle_cnt  <= '0;
            div_cnt     <= '0;
            pend_full   <= 1'b0;
            pend_data   <= '0;
            cur         <= '0;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
            in_ready    <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_n;
            settle_cnt  <= settle_n;
            div_cnt     <= div_n;
            pend_full   <= pend_full_n;
            pend_data   <= pend_data_n;
            cur         <= cur_n;
            sample_tick <= tick_n;
            underrun    <= underrun_n;
            in_ready    <= in_ready_n;
            active      <= active_n;
        end
    end

    // Next-state, divider, handshake and sample hand-over logic
    always_comb begin
        state_n     = state;
        settle_n    = settle_cnt;
        div_n       = '0;
        pend_full_n = pend_full;
        pend_data_n = pend_data;
        cur_n       = cur;
        tick_n      = 1'b0;
        underrun_n  = 1'b0;
        xfer_c      = in_valid && in_ready;

        case (state)
            WAIT_LOCK: begin
                settle_n = '0;
                if (locked) begin
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (!locked) begin
                    state_n  = WAIT_LOCK;
                    settle_n = '0;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_n  = RUN;
                    settle_n = '0;
                end else begin
                    settle_n = settle_cnt + SW'(1);
                end
            end
            RUN: begin
                if (!locked) begin
                    state_n = WAIT_LOCK;
                end else begin
                    div_n  = (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
                    tick_n = (div_cnt == DIV_LAST);
                    if (sample_tick) begin
                        if (pend_full) begin
                            cur_n       = pend_data;
                            pend_full_n = 1'b0;
                        end else if (xfer_c) begin
                            // Sample arriving on the tick bypasses the buffer
                            cur_n = in_data;
                        end else begin
                            underrun_n = 1'b1;
                        end
                    end else if (xfer_c) begin
                        pend_data_n = in_data;
                        pend_full_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = WAIT_LOCK;
            end
        endcase

        // Losing lock (or never having it) flushes everything back to midscale
        if (state_n == WAIT_LOCK) begin
            settle_n    = '0;
            div_n       = '0;
            pend_full_n = 1'b0;
            pend_data_n = '0;
            cur_n       = '0;
            tick_n      = 1'b0;
            underrun_n  = 1'b0;
        end

        in_ready_n = (state_n == RUN) && !pend_full_n;
        active_n   = (state_n == RUN);
        clr_c      = (state_n == WAIT_LOCK);
    end

    // Modulator input in offset binary
    assign u_c = BITS'(to_offset_binary(BITS_MAX'(cur), BITS));

    dac_dsm1 #(
        .BITS(BITS)
    ) u_dsm (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_c),
        .en     (1'b1),
        .u      (u_c),
        .bit_out(dac_out)
    );

endmodule
